// File: rtl/cdc_hs_tx_ctrl.sv
// Source-side (clkA) four-phase req/ack controller that carries a DATA_W word into clkB.
// The returning ack is synchronized here, and each handshake phase is bounded by TIMEOUT cycles.
module cdc_hs_tx_ctrl #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clkA,
    input  logic              rstA,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack_async,
    output logic              done,
    output logic              timeout_err,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cdc_hs_tx_ctrl: SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("cdc_hs_tx_ctrl: TIMEOUT must be in 0..65535");
    end

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       wait_q, wait_d;
    logic              aborted_q, aborted_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic [7:0]        err_q, err_d;
    logic              ready_q, ready_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_sync;
    logic                   phase_expired;

    // The only place the asynchronous ack is sampled.
    always_ff @(posedge clkA) begin
        if (rstA) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], xfer_ack_async};
        end
    end

    assign ack_sync      = sync_q[SYNC_STAGES-1];
    assign phase_expired = TO_EN && (wait_q == TO_LAST);

    always_ff @(posedge clkA) begin
        if (rstA) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            wait_q    <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            err_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            wait_q    <= wait_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    // An ack seen in the same cycle as an expiring phase always wins over the timeout.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        wait_d    = wait_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        tmo_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (src_valid && ready_q) begin
                    data_d    = src_data;
                    req_d     = 1'b1;
                    aborted_d = 1'b0;
                    wait_d    = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    req_d   = 1'b0;
                    wait_d  = '0;
                    state_d = ST_REL;
                end else if (phase_expired) begin
                    tmo_d     = 1'b1;
                    req_d     = 1'b0;
                    aborted_d = 1'b1;
                    wait_d    = '0;
                    state_d   = ST_REL;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_REL: begin
                req_d = 1'b0;
                if (!ack_sync) begin
                    done_d  = !aborted_q;
                    state_d = ST_IDLE;
                end else if (phase_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        err_d   = (tmo_d && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        ready_d = (state_d == ST_IDLE);
    end

    assign src_ready   = ready_q;
    assign xfer_req    = req_q;
    assign xfer_data   = data_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign err_cnt     = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
